// File: rtl/mem_burst_pkg.sv
// Shared beat/line geometry and FSM/op encodings for the burst memory responder.
package mem_burst_pkg;

    localparam int BEAT_W     = 64;
    localparam int LINE_W     = 256;
    localparam int BEATS      = 4;
    localparam int BEAT_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } burst_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } burst_op_t;

endpackage

// File: rtl/burst_mem_array.sv
// Line storage: DEPTH_LINES x 256-bit, beat-granular write, registered 64-bit beat read.
module burst_mem_array
    import mem_burst_pkg::*;
#(
    parameter int DEPTH_LINES = 64,
    parameter int LINE_AW     = $clog2(DEPTH_LINES)
) (
    input  logic                  clk,
    input  logic [LINE_AW-1:0]    wr_line,
    input  logic [BEATS-1:0]      wr_beat_en,
    input  logic [BEAT_W-1:0]     wr_data,
    input  logic [LINE_AW-1:0]    rd_line,
    input  logic [BEAT_IDX_W-1:0] rd_beat,
    output logic [BEAT_W-1:0]     rd_data
);

    logic [LINE_W-1:0] line_mem [DEPTH_LINES];

    // No reset: storage contents must survive rst so committed beats persist.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BEATS; b++) begin
            if (wr_beat_en[b]) begin
                line_mem[wr_line][b*BEAT_W +: BEAT_W] <= wr_data;
            end
        end
        rd_data <= line_mem[rd_line][32'(rd_beat)*BEAT_W +: BEAT_W];
    end

endmodule

// File: rtl/burst_mem_responder.sv
// Line-granular burst memory responder: fixed request-to-data latency, four 64-bit beats per line.
module burst_mem_responder
    import mem_burst_pkg::*;
#(
    parameter int LATENCY     = 3,
    parameter int DEPTH_LINES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_addr,
    input  logic [BEAT_W-1:0] mem_wdata,
    output logic [BEAT_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              err
);

    localparam int         LINE_AW   = $clog2(DEPTH_LINES);
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    burst_state_t            state_reg, state_next;
    burst_op_t               op_reg, op_next;
    logic [LINE_AW-1:0]      line_reg, line_next;
    logic [3:0]              wait_cnt_reg, wait_cnt_next;
    logic [BEAT_IDX_W-1:0]   beat_reg, beat_next;
    logic                    resp_reg, resp_next;
    logic                    err_reg, err_next;

    logic                    req_one;
    logic                    req_both;
    logic                    req_held;
    logic [LINE_AW-1:0]      addr_line;
    logic [BEATS-1:0]        wr_beat_en;
    logic [LINE_AW-1:0]      rd_line;
    logic [BEAT_IDX_W-1:0]   rd_beat;
    logic [BEAT_W-1:0]       rd_data;
    logic                    unused_addr_bits;

    assign req_one   = mem_read ^ mem_write;
    assign req_both  = mem_read & mem_write;
    assign req_held  = (op_reg == OP_WRITE) ? mem_write : mem_read;
    assign addr_line = mem_addr[LINE_AW+4:5];
    assign unused_addr_bits = ^{mem_addr[31:LINE_AW+5], mem_addr[4:0]};

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        line_next     = line_reg;
        wait_cnt_next = wait_cnt_reg;
        beat_next     = beat_reg;
        err_next      = err_reg;
        case (state_reg)
            IDLE: begin
                if (req_both) begin
                    err_next = 1'b1;
                end else if (req_one) begin
                    op_next       = mem_write ? OP_WRITE : OP_READ;
                    line_next     = addr_line;
                    wait_cnt_next = WAIT_LOAD;
                    beat_next     = '0;
                    // The WAIT phase lasts LATENCY-1 cycles, so LATENCY=1 skips it.
                    state_next    = (LATENCY == 1) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!req_held) begin
                    state_next    = IDLE;
                    err_next      = 1'b1;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg <= 4'd1) begin
                    state_next    = BURST;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            BURST: begin
                if (!req_held) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                    beat_next  = '0;
                end else if (beat_reg == BEAT_IDX_W'(BEATS - 1)) begin
                    state_next = DONE;
                    beat_next  = '0;
                end else begin
                    beat_next  = beat_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The strobe is registered straight from the next state, so it is high exactly in BURST.
    assign resp_next = (state_next == BURST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            op_reg       <= OP_READ;
            line_reg     <= '0;
            wait_cnt_reg <= '0;
            beat_reg     <= '0;
            resp_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            line_reg     <= line_next;
            wait_cnt_reg <= wait_cnt_next;
            beat_reg     <= beat_next;
            resp_reg     <= resp_next;
            err_reg      <= err_next;
        end
    end

    // A beat commits only while the initiator still holds its write request.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat_we
            assign wr_beat_en[gi] = (state_reg == BURST) && (op_reg == OP_WRITE) &&
                                    mem_write && (beat_reg == BEAT_IDX_W'(gi));
        end
    endgenerate

    // Read address runs one beat ahead so the registered RAM output lines up with the strobe.
    assign rd_line = (state_reg == IDLE) ? addr_line : line_reg;
    assign rd_beat = (state_reg == BURST) ? beat_reg + 1'b1 : '0;

    burst_mem_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .LINE_AW     (LINE_AW)
    ) u_array (
        .clk        (clk),
        .wr_line    (line_reg),
        .wr_beat_en (wr_beat_en),
        .wr_data    (mem_wdata),
        .rd_line    (rd_line),
        .rd_beat    (rd_beat),
        .rd_data    (rd_data)
    );

    assign mem_rdata = resp_reg ? rd_data : '0;
    assign mem_resp  = resp_reg;
    assign err       = err_reg;

endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3: cycles from request acceptance to first beat; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LINES, default 64: number of 256-bit lines stored; power of two.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port mem_read, input, 1: initiator line-read request, held high until the last beat.
REQ-006 SHALL have port mem_write, input, 1: initiator line-write request, held high until the last beat.
REQ-007 SHALL have port mem_addr, input, 32: byte address of the line; bits [4:0] are ignored.
REQ-008 SHALL have port mem_wdata, input, 64: write beat from the initiator.
REQ-009 SHALL have port mem_rdata, output, 64: read beat, registered.
REQ-010 SHALL have port mem_resp, output, 1: beat-valid strobe, registered.
REQ-011 SHALL have port err, output, 1: sticky protocol-error flag.

Function
REQ-012 SHALL use FSM states IDLE, WAIT, BURST, DONE.
REQ-013 SHALL accept a request in IDLE when exactly one of mem_read/mem_write is high; it latches op, line index = mem_addr[4+log2(DEPTH_LINES):5] and loads the wait counter.
REQ-014 SHALL wrap out-of-range addresses modulo DEPTH_LINES and SHALL NOT flag them as errors.
REQ-015 SHALL, for a request accepted in cycle N, drive mem_resp=1 in cycles N+LATENCY through N+LATENCY+3, and 0 otherwise.
REQ-016 SHALL, on a read, drive beat k (line bits [64k+63:64k], k=0..3) on mem_rdata in the k-th mem_resp cycle, and drive mem_rdata='0 whenever mem_resp=0.
REQ-017 SHALL, on a write, capture mem_wdata into line beat k at the rising edge that ends the k-th mem_resp cycle; each beat commits independently.
REQ-018 SHALL use a 2-bit beat counter in BURST and leave BURST after beat 3.
REQ-019 SHALL enter DONE for exactly one cycle after beat 3 with mem_resp=0, ignore requests in DONE, and then return to IDLE. This gives the initiator one cycle to drop its request.
REQ-020 SHALL, when mem_read and mem_write are both high in IDLE, not accept the request, set err, and remain in IDLE.
REQ-021 SHALL, when the latched request signal drops in WAIT or BURST, abort to IDLE, set err, and deassert mem_resp the next cycle; beats already written stay committed.
REQ-022 SHALL ignore changes to mem_addr after acceptance.
REQ-023 SHALL make a read issued after a completed write to the same line return the written data.

Reset
REQ-024 SHALL, while rst=0, force state=IDLE, mem_resp=0, mem_rdata='0, err=0, and clear both counters, asynchronously.
REQ-025 SHALL NOT reset line storage contents.
REQ-026 SHALL, on reset mid-burst, drop the burst; beats already committed remain in storage.
REQ-027 SHALL accept a request no earlier than the first rising edge after rst deasserts.

Structure
REQ-028 SHALL take the state enum and the constants BEAT_W=64, LINE_W=256 and BEATS=4 from shared package mem_burst_pkg.
REQ-029 SHALL instantiate one sub-module, burst_mem_array: DEPTH_LINES x 256-bit storage with one read port and a beat-granular write enable.
REQ-030 SHALL be synthesizable, with no delays and no initial blocks.

Verification
REQ-031 SHALL verify write-then-read: LATENCY=3, write line 0x40 with beats 0x1111..,0x2222..,0x3333..,0x4444.. -> mem_resp high in cycles N+3..N+6; a subsequent read of 0x40 returns the same beats in order, with mem_rdata=0 outside the resp cycles.
REQ-032 SHALL verify offset and wrap: with DEPTH_LINES=64, write 0x40, then read 0x840 and 0x5F -> both return the 0x40 line data, err=0.
REQ-033 SHALL verify simultaneous read and write: mem_read=mem_write=1 in IDLE -> no mem_resp for 10 cycles, err=1 and it stays 1.
REQ-034 SHALL verify mid-burst abort: mem_read dropped after beat 1 -> mem_resp=0 the next cycle, err=1, and a new read is accepted normally afterwards.
REQ-035 SHALL verify reset mid-write: rst=0 during beat 2 of a write -> outputs go to 0 immediately; a later read shows beats 0..1 new and beats 2..3 old.
REQ-036 SHALL verify back-to-back requests: a request held through DONE -> accepted the cycle after DONE, with first resp LATENCY cycles later.
